// File: rtl/nabp_angle_sequencer.sv
// Angle sequencer for the back-projection pipeline.
// Steps through ANGLE_LENGTH projection angles per run. Each angle is loaded,
// held in a fixed-length preprocessing window, then offered downstream until
// the swap control accepts it.
//
// Handshake: angle/angle_idx are stable for as long as angle_valid is high.
// A transfer happens on a rising clk edge where angle_valid and
// next_angle_ack are both high. angle_valid drops the cycle after a transfer.
// next_angle_ack is ignored while angle_valid is low.
//
// dbg_state exposes the FSM state register for observation.
module nabp_angle_sequencer #(
    parameter int ANGLE_LENGTH   = 180,
    parameter int ANGLE_WIDTH    = 8,
    parameter int ANGLE_START    = 0,
    parameter int ANGLE_STEP     = 1,
    parameter int ANGLE_WRAP     = 180,
    parameter int PREPROC_CYCLES = 4,
    localparam int IDX_W = (ANGLE_LENGTH > 1) ? $clog2(ANGLE_LENGTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   na_kick,
    input  logic                   next_angle_ack,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [IDX_W-1:0]       angle_idx,
    output logic                   angle_valid,
    output logic                   has_next_angle,
    output logic                   preprocess_done,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             dbg_state
);

    localparam int CNT_W = (PREPROC_CYCLES > 1) ? $clog2(PREPROC_CYCLES) : 1;

    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(ANGLE_LENGTH - 1);
    localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(PREPROC_CYCLES - 1);
    localparam logic [ANGLE_WIDTH-1:0] START_VAL = ANGLE_WIDTH'(ANGLE_START);
    localparam logic [ANGLE_WIDTH:0]   STEP_EXT  = (ANGLE_WIDTH + 1)'(ANGLE_STEP);
    localparam logic [ANGLE_WIDTH:0]   WRAP_EXT  = (ANGLE_WIDTH + 1)'(ANGLE_WRAP);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        PREPROCESS = 3'd2,
        READY      = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       pre_cnt;
    logic [ANGLE_WIDTH:0]   angle_sum;
    logic [ANGLE_WIDTH:0]   angle_mod;

    // Modular angle advance, one bit wider than the angle so that the sum
    // cannot overflow before the wrap comparison.
    always_comb begin
        angle_sum = {1'b0, angle} + STEP_EXT;
        angle_mod = angle_sum;
        if (angle_sum >= WRAP_EXT) begin
            angle_mod = angle_sum - WRAP_EXT;
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            angle           <= START_VAL;
            angle_idx       <= '0;
            pre_cnt         <= '0;
            angle_valid     <= 1'b0;
            preprocess_done <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            preprocess_done <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (na_kick) begin
                        state     <= LOAD;
                        angle_idx <= '0;
                        angle     <= START_VAL;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    pre_cnt <= CNT_LOAD;
                    state   <= PREPROCESS;
                end
                PREPROCESS: begin
                    if (pre_cnt == '0) begin
                        state           <= READY;
                        preprocess_done <= 1'b1;
                        angle_valid     <= 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt - 1'b1;
                    end
                end
                READY: begin
                    if (next_angle_ack) begin
                        angle_valid <= 1'b0;
                        if (angle_idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            angle_idx <= angle_idx + 1'b1;
                            angle     <= ANGLE_WIDTH'(angle_mod);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    angle_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign has_next_angle = (state != IDLE) && (state != DONE) && (angle_idx < LAST_IDX);
    assign dbg_state      = state;

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Bench for nabp_angle_sequencer: three instances (default run, stepped/wrapping
// run with ack held high, single-angle run). Expected angles are pushed into
// per-instance queues when a run is kicked; negedge monitors pop on every
// preprocess_done and compare.
module tb_nabp_angle_sequencer;

    localparam int A_LEN  = 180;
    localparam int A_PC   = 4;
    localparam int B_LEN  = 30;
    localparam int B_STEP = 7;
    localparam int B_WRAP = 180;
    localparam int B_PC   = 1;
    localparam int C_LEN  = 1;
    localparam int C_START = 5;
    localparam int C_PC   = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    // instance A: all defaults
    logic       rst_a_n, kick_a, ack_a;
    logic [7:0] angle_a;
    logic [7:0] idx_a;
    logic       valid_a, hasnext_a, pdone_a, busy_a, done_a;
    logic [2:0] dbg_a;

    // instance B: step 7, 30 angles, 1 preprocess cycle
    logic       rst_b_n, kick_b, ack_b;
    logic [7:0] angle_b;
    logic [4:0] idx_b;
    logic       valid_b, hasnext_b, pdone_b, busy_b, done_b;
    logic [2:0] dbg_b;

    // instance C: single angle starting at 5
    logic       rst_c_n, kick_c, ack_c;
    logic [7:0] angle_c;
    logic [0:0] idx_c;
    logic       valid_c, hasnext_c, pdone_c, busy_c, done_c;
    logic [2:0] dbg_c;

    nabp_angle_sequencer u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .na_kick(kick_a), .next_angle_ack(ack_a),
        .angle(angle_a), .angle_idx(idx_a), .angle_valid(valid_a),
        .has_next_angle(hasnext_a), .preprocess_done(pdone_a), .busy(busy_a),
        .done(done_a), .dbg_state(dbg_a)
    );

    nabp_angle_sequencer #(
        .ANGLE_LENGTH(B_LEN), .ANGLE_STEP(B_STEP), .ANGLE_WRAP(B_WRAP),
        .PREPROC_CYCLES(B_PC)
    ) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .na_kick(kick_b), .next_angle_ack(ack_b),
        .angle(angle_b), .angle_idx(idx_b), .angle_valid(valid_b),
        .has_next_angle(hasnext_b), .preprocess_done(pdone_b), .busy(busy_b),
        .done(done_b), .dbg_state(dbg_b)
    );

    nabp_angle_sequencer #(
        .ANGLE_LENGTH(C_LEN), .ANGLE_START(C_START), .PREPROC_CYCLES(C_PC)
    ) u_dut_c (
        .clk(clk), .reset_n(rst_c_n), .na_kick(kick_c), .next_angle_ack(ack_c),
        .angle(angle_c), .angle_idx(idx_c), .angle_valid(valid_c),
        .has_next_angle(hasnext_c), .preprocess_done(pdone_c), .busy(busy_c),
        .done(done_c), .dbg_state(dbg_c)
    );

    // reference model: angle i of a run is (start + i*step) mod wrap
    function automatic int ref_angle(input int start, input int step, input int wrap, input int i);
        return (start + i * step) % wrap;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // scoreboard state
    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];
    logic [15:0] exp_q_c[$];
    int t_acc_a = 0, t_acc_b = 0, t_acc_c = 0;
    int pd_cnt_a = 0, pd_cnt_b = 0, pd_cnt_c = 0;
    int dn_cnt_a = 0, dn_cnt_b = 0, dn_cnt_c = 0;
    bit done_chk_a = 0, done_chk_b = 0, done_chk_c = 0;

    // monitor A
    always @(negedge clk) begin : mon_a
        logic [15:0] e;
        if (rst_a_n) begin
            if (pdone_a) begin
                pd_cnt_a++;
                if (exp_q_a.size() == 0) begin
                    timeout_fail("a_unexpected_angle");
                end else begin
                    e = exp_q_a.pop_front();
                    check("a_idx_angle", {idx_a, angle_a}, e);
                    check("a_valid_at_ready", valid_a, 1'b1);
                    check("a_has_next", hasnext_a, (e[15:8] < A_LEN - 1));
                    check("a_latency", cyc - t_acc_a, A_PC + 1);
                end
            end
            if (done_chk_a) begin
                check("a_busy_done_after_done", {busy_a, done_a}, 2'b00);
                done_chk_a = 0;
            end
            if (done_a) begin
                dn_cnt_a++;
                check("a_queue_empty_at_done", exp_q_a.size(), 0);
                check("a_last_idx_at_done", idx_a, A_LEN - 1);
                done_chk_a = 1;
            end
            if (valid_a && ack_a) t_acc_a = cyc + 1;
        end
    end

    // monitor B
    always @(negedge clk) begin : mon_b
        logic [15:0] e;
        if (rst_b_n) begin
            if (pdone_b) begin
                pd_cnt_b++;
                if (exp_q_b.size() == 0) begin
                    timeout_fail("b_unexpected_angle");
                end else begin
                    e = exp_q_b.pop_front();
                    check("b_idx_angle", {idx_b, angle_b}, e);
                    check("b_has_next", hasnext_b, (e[15:8] < B_LEN - 1));
                    check("b_latency", cyc - t_acc_b, B_PC + 1);
                end
            end
            if (done_chk_b) begin
                check("b_busy_done_after_done", {busy_b, done_b}, 2'b00);
                done_chk_b = 0;
            end
            if (done_b) begin
                dn_cnt_b++;
                check("b_queue_empty_at_done", exp_q_b.size(), 0);
                check("b_last_angle_held", angle_b, ref_angle(0, B_STEP, B_WRAP, B_LEN - 1));
                done_chk_b = 1;
            end
            if (valid_b && ack_b) t_acc_b = cyc + 1;
        end
    end

    // monitor C
    always @(negedge clk) begin : mon_c
        logic [15:0] e;
        if (rst_c_n) begin
            if (busy_c) check("c_has_next_never", hasnext_c, 1'b0);
            if (pdone_c) begin
                pd_cnt_c++;
                if (exp_q_c.size() == 0) begin
                    timeout_fail("c_unexpected_angle");
                end else begin
                    e = exp_q_c.pop_front();
                    check("c_idx_angle", {idx_c, angle_c}, e);
                    check("c_latency", cyc - t_acc_c, C_PC + 1);
                end
            end
            if (done_chk_c) begin
                check("c_busy_done_after_done", {busy_c, done_c}, 2'b00);
                done_chk_c = 0;
            end
            if (done_c) dn_cnt_c++;
        end
    end

    // driver tasks
    task automatic kick_a_pulse();
        @(posedge clk); #1 kick_a = 1'b1;
        @(posedge clk); #1 t_acc_a = cyc;
        kick_a = 1'b0;
    endtask

    task automatic wait_valid_a(output bit ok);
        int w = 0;
        while (!valid_a && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        ok = valid_a;
        if (!ok) timeout_fail("a_valid_wait");
    endtask

    task automatic ack_loop_a(input int n, input bit with_kicks);
        for (int k = 0; k < n; k++) begin
            bit ok;
            wait_valid_a(ok);
            if (!ok) return;
            repeat ($urandom_range(0, 2)) begin
                kick_a = with_kicks && ($urandom_range(0, 2) == 0);
                @(posedge clk); #1;
            end
            kick_a = 1'b0;
            ack_a  = 1'b1;
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            ack_a = 1'b0;
        end
    endtask

    task automatic wait_done_a(input int target);
        int w = 0;
        while (dn_cnt_a < target && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        if (dn_cnt_a < target) timeout_fail("a_done_wait");
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_a(input bit with_kicks, input int target);
        for (int i = 0; i < A_LEN; i++)
            exp_q_a.push_back({8'(i), 8'(ref_angle(0, 1, 180, i))});
        kick_a_pulse();
        ack_loop_a(A_LEN, with_kicks);
        wait_done_a(target);
    endtask

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 0; kick_a = 0; ack_a = 0;
        rst_b_n = 0; kick_b = 0; ack_b = 0;
        rst_c_n = 0; kick_c = 0; ack_c = 0;

        // ---- A: reset state, kick held across reset release ----
        kick_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("a_reset_angle", angle_a, 0);
        check("a_reset_idx", idx_a, 0);
        check("a_reset_flags", {valid_a, hasnext_a, pdone_a, busy_a, done_a}, 5'b0);
        rst_a_n = 1'b1;
        kick_a  = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("a_kick_at_reset_ignored", busy_a, 1'b0);

        // ---- A: full run with random ack timing and stray kicks ----
        run_a(1'b1, 1);
        check("a_done_count_run1", dn_cnt_a, 1);

        // ---- A: abort in PREPROCESS at angle_idx 5 ----
        for (int i = 0; i < 5; i++)
            exp_q_a.push_back({8'(i), 8'(ref_angle(0, 1, 180, i))});
        kick_a_pulse();
        ack_loop_a(4, 1'b0);
        begin
            bit ok;
            wait_valid_a(ok);
        end
        ack_a = 1'b1;
        @(posedge clk); #1;
        ack_a = 1'b0;
        @(posedge clk); #1;
        check("a_pre_abort_idx", idx_a, 5);
        check("a_pre_abort_valid", valid_a, 1'b0);
        check("a_pre_abort_queue", exp_q_a.size(), 0);
        rst_a_n = 1'b0;
        #1;
        check("a_abort_angle", angle_a, 0);
        check("a_abort_idx", idx_a, 0);
        check("a_abort_flags", {valid_a, hasnext_a, pdone_a, busy_a, done_a}, 5'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_a_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("a_no_restart_without_kick", busy_a, 1'b0);
        check("a_no_done_on_abort", dn_cnt_a, 1);

        // ---- A: restart after abort ----
        run_a(1'b0, 2);
        check("a_pdone_total", pd_cnt_a, 2 * A_LEN + 5);
        check("a_done_total", dn_cnt_a, 2);

        // ---- B: wrapping step, ack held high ----
        @(posedge clk); #1;
        check("b_reset_angle", angle_b, 0);
        rst_b_n = 1'b1;
        ack_b   = 1'b1;
        for (int i = 0; i < B_LEN; i++)
            exp_q_b.push_back({8'(i), 8'(ref_angle(0, B_STEP, B_WRAP, i))});
        @(posedge clk); #1 kick_b = 1'b1;
        @(posedge clk); #1 t_acc_b = cyc;
        kick_b = 1'b0;
        begin
            int w = 0;
            while (dn_cnt_b < 1 && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            if (dn_cnt_b < 1) timeout_fail("b_done_wait");
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        ack_b = 1'b0;
        check("b_pdone_total", pd_cnt_b, B_LEN);
        check("b_done_total", dn_cnt_b, 1);

        // ---- C: single angle, kick during READY ignored ----
        check("c_reset_angle", angle_c, C_START);
        check("c_reset_flags", {valid_c, hasnext_c, pdone_c, busy_c, done_c}, 5'b0);
        rst_c_n = 1'b1;
        exp_q_c.push_back({8'd0, 8'(C_START)});
        @(posedge clk); #1 kick_c = 1'b1;
        @(posedge clk); #1 t_acc_c = cyc;
        kick_c = 1'b0;
        begin
            int w = 0;
            while (!valid_c && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            if (!valid_c) timeout_fail("c_valid_wait");
        end
        kick_c = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        kick_c = 1'b0;
        check("c_valid_after_kick", valid_c, 1'b1);
        check("c_idx_after_kick", {idx_c, angle_c}, {1'b0, 8'(C_START)});
        ack_c = 1'b1;
        @(posedge clk); #1;
        ack_c = 1'b0;
        begin
            int w = 0;
            while (dn_cnt_c < 1 && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            if (dn_cnt_c < 1) timeout_fail("c_done_wait");
        end
        done_chk_c = 1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("c_pdone_total", pd_cnt_c, 1);
        check("c_done_total", dn_cnt_c, 1);
        check("c_angle_held", angle_c, C_START);
        check("c_queue_empty", exp_q_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
